// File: rtl/cache_addr_encoder.sv
// Cache address encoder: composes {tag, index, 2'b00} byte addresses for
// eviction writebacks and refill reads, buffers up to two writebacks in a
// small FIFO, and arbitrates both streams onto one memory request port.
// Writebacks always win over a pending refill.
module cache_addr_encoder #(
    parameter int INDEX_W = 5,
    localparam int TAG_W  = 30 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    // eviction writeback request
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [TAG_W-1:0]   wb_tag,
    input  logic [INDEX_W-1:0] wb_index,
    input  logic [31:0]        wb_data,
    // refill (miss) request
    input  logic               rf_valid,
    output logic               rf_ready,
    input  logic [TAG_W-1:0]   rf_tag,
    input  logic [INDEX_W-1:0] rf_index,
    // memory request / response
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    // refill completion
    output logic               rf_done,
    output logic [31:0]        rf_data
);

    typedef enum logic [1:0] {IDLE, WB_REQ, RF_REQ, RF_WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        rf_pending_q, rf_pending_d;
    logic [31:0] rf_addr_q, rf_addr_d;
    logic        rf_done_q, rf_done_d;
    logic [31:0] rf_data_q, rf_data_d;

    logic [31:0] entry_addr [2];
    logic [31:0] entry_data [2];
    logic [31:0] head_addr, head_data;
    logic [31:0] wb_addr_in, rf_addr_in;
    logic        wb_push, wb_pop, rf_accept, rd_resp;

    // Block offset is always zero: one word per line.
    assign wb_addr_in = {wb_tag, wb_index, 2'b00};
    assign rf_addr_in = {rf_tag, rf_index, 2'b00};

    assign wb_ready  = (count_q != 2'd2);
    assign rf_ready  = (state_q == IDLE) && !rf_pending_q;
    assign wb_push   = wb_valid && wb_ready;
    assign rf_accept = rf_valid && rf_ready;
    assign wb_pop    = (state_q == WB_REQ) && mem_ready;
    assign rd_resp   = (state_q == RF_WAIT) && mem_rvalid;

    assign head_addr = rd_ptr_q ? entry_addr[1] : entry_addr[0];
    assign head_data = rd_ptr_q ? entry_data[1] : entry_data[0];

    assign rf_done = rf_done_q;
    assign rf_data = rf_data_q;

    // Writeback FIFO storage: each slot loads only when the write pointer selects it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        localparam logic SLOT = 1'(gi);
        logic [31:0] addr_q, addr_d;
        logic [31:0] data_q, data_d;

        // Next-value of this slot.
        always_comb begin
            addr_d = addr_q;
            data_d = data_q;
            if (wb_push && (wr_ptr_q == SLOT)) begin
                addr_d = wb_addr_in;
                data_d = wb_data;
            end
        end

        // Slot registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_q <= '0;
                data_q <= '0;
            end else begin
                addr_q <= addr_d;
                data_q <= data_d;
            end
        end

        assign entry_addr[gi] = addr_q;
        assign entry_data[gi] = data_q;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_comb begin
        wr_ptr_d = wb_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = wb_pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({wb_push, wb_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Refill bookkeeping: latch the address on accept, capture data on response.
    always_comb begin
        rf_pending_d = rf_pending_q;
        rf_addr_d    = rf_addr_q;
        rf_done_d    = rd_resp;
        rf_data_d    = rf_data_q;
        if (rf_accept) begin
            rf_pending_d = 1'b1;
            rf_addr_d    = rf_addr_in;
        end
        if (rd_resp) begin
            rf_pending_d = 1'b0;
            rf_data_d    = mem_rdata;
        end
    end

    // Datapath and FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            rf_pending_q <= 1'b0;
            rf_addr_q    <= '0;
            rf_done_q    <= 1'b0;
            rf_data_q    <= '0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rf_pending_q <= rf_pending_d;
            rf_addr_q    <= rf_addr_d;
            rf_done_q    <= rf_done_d;
            rf_data_q    <= rf_data_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a request arriving this cycle is seen so memory starts next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((count_q != 2'd0) || wb_push)   state_d = WB_REQ;
                else if (rf_pending_q || rf_accept) state_d = RF_REQ;
            end
            WB_REQ:  if (mem_ready)  state_d = IDLE;
            RF_REQ:  if (mem_ready)  state_d = RF_WAIT;
            RF_WAIT: if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; request fields are zero whenever no request is presented.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WB_REQ: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head_addr;
                mem_wdata = head_data;
            end
            RF_REQ: begin
                mem_valid = 1'b1;
                mem_addr  = rf_addr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_addr_encoder.sv
// Bench for cache_addr_encoder: instance 0 uses INDEX_W=5, instance 1 uses INDEX_W=2.
// A transaction-level model checks both instances every cycle; directed
// sequences pin exact cycle behaviour with hand-computed literals.
module tb_cache_addr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        wb_valid [2];
    logic        wb_ready [2];
    logic [31:0] wb_tag   [2];
    logic [4:0]  wb_index [2];
    logic [31:0] wb_data  [2];
    logic        rf_valid [2];
    logic        rf_ready [2];
    logic [31:0] rf_tag   [2];
    logic [4:0]  rf_index [2];
    logic        mem_valid[2];
    logic        mem_ready[2];
    logic        mem_we   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic        mem_rvalid[2];
    logic [31:0] mem_rdata[2];
    logic        rf_done  [2];
    logic [31:0] rf_data  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // model state per instance
    int          m_cnt  [2];
    int          m_head [2];
    logic [31:0] m_qa   [2][4];
    logic [31:0] m_qd   [2][4];
    bit          m_pend [2];
    bit          m_outst[2];
    bit          m_done [2];
    logic [31:0] m_paddr[2];
    logic [31:0] m_rdata[2];

    always #5 clk = ~clk;

    cache_addr_encoder #(.INDEX_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid[0]), .wb_ready(wb_ready[0]),
        .wb_tag(wb_tag[0][24:0]), .wb_index(wb_index[0][4:0]), .wb_data(wb_data[0]),
        .rf_valid(rf_valid[0]), .rf_ready(rf_ready[0]),
        .rf_tag(rf_tag[0][24:0]), .rf_index(rf_index[0][4:0]),
        .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[0]),
        .rf_done(rf_done[0]), .rf_data(rf_data[0])
    );

    cache_addr_encoder #(.INDEX_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid[1]), .wb_ready(wb_ready[1]),
        .wb_tag(wb_tag[1][27:0]), .wb_index(wb_index[1][1:0]), .wb_data(wb_data[1]),
        .rf_valid(rf_valid[1]), .rf_ready(rf_ready[1]),
        .rf_tag(rf_tag[1][27:0]), .rf_index(rf_index[1][1:0]),
        .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata[1]),
        .rf_done(rf_done[1]), .rf_data(rf_data[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte address as plain arithmetic: tag * 2^(index bits + 2) + index * 4.
    function automatic logic [31:0] compose(input int iw, input logic [31:0] tag, input logic [4:0] idx);
        logic [31:0] tmask;
        logic [31:0] imask;
        tmask = (32'h1 << (30 - iw)) - 32'h1;
        imask = (32'h1 << iw) - 32'h1;
        return (tag & tmask) * (32'h1 << (iw + 2)) + ({27'h0, idx} & imask) * 32'd4;
    endfunction

    task automatic model_reset(input int k);
        m_cnt[k] = 0; m_head[k] = 0; m_pend[k] = 0;
        m_outst[k] = 0; m_done[k] = 0;
    endtask

    task automatic model_cycle(input int k);
        int iw;
        bit push, pop, done_next;
        iw = (k == 0) ? 5 : 2;
        pop = 0;
        done_next = 0;
        chk($sformatf("d%0d_wb_ready", k), wb_ready[k], (m_cnt[k] < 2));
        chk($sformatf("d%0d_rf_ready", k), rf_ready[k], (!m_pend[k] && !mem_valid[k]));
        chk($sformatf("d%0d_rf_done", k), rf_done[k], m_done[k]);
        if (m_done[k]) chk($sformatf("d%0d_rf_data", k), rf_data[k], m_rdata[k]);
        if (mem_valid[k]) begin
            n_cmp++;
            if (mem_we[k]) begin
                if (m_cnt[k] == 0) begin
                    n_fail++;
                    $display("FAIL d%0d_write_legal: actual=write required=none queued", k);
                end else begin
                    chk($sformatf("d%0d_wr_addr", k), mem_addr[k], m_qa[k][m_head[k]]);
                    chk($sformatf("d%0d_wr_data", k), mem_wdata[k], m_qd[k][m_head[k]]);
                    pop = mem_ready[k];
                end
            end else begin
                if (!m_pend[k] || m_outst[k]) begin
                    n_fail++;
                    $display("FAIL d%0d_read_legal: actual=read required=none pending", k);
                end else begin
                    chk($sformatf("d%0d_rd_addr", k), mem_addr[k], m_paddr[k]);
                    if (mem_ready[k]) m_outst[k] = 1;
                end
            end
            if (mem_ready[k])
                $display("dut%0d mem %s addr=%h wdata=%h", k, mem_we[k] ? "WR" : "RD", mem_addr[k], mem_wdata[k]);
        end else begin
            chk($sformatf("d%0d_idle_we", k), mem_we[k], 0);
            chk($sformatf("d%0d_idle_addr", k), mem_addr[k], 0);
            chk($sformatf("d%0d_idle_wdata", k), mem_wdata[k], 0);
        end
        // refill response only counts while a read is outstanding
        if (m_outst[k] && mem_rvalid[k] && !(mem_valid[k] && !mem_we[k])) begin
            done_next = 1;
            m_rdata[k] = mem_rdata[k];
            m_outst[k] = 0;
            m_pend[k] = 0;
            $display("dut%0d refill data=%h", k, mem_rdata[k]);
        end
        push = wb_valid[k] && (m_cnt[k] < 2);
        if (push) begin
            m_qa[k][(m_head[k] + m_cnt[k]) % 4] = compose(iw, wb_tag[k], wb_index[k]);
            m_qd[k][(m_head[k] + m_cnt[k]) % 4] = wb_data[k];
            $display("dut%0d wb push addr=%h data=%h", k, compose(iw, wb_tag[k], wb_index[k]), wb_data[k]);
        end
        if (pop) m_head[k] = (m_head[k] + 1) % 4;
        m_cnt[k] = m_cnt[k] + int'(push) - int'(pop);
        if (rf_valid[k] && !m_pend[k] && !mem_valid[k]) begin
            m_pend[k] = 1;
            m_paddr[k] = compose(iw, rf_tag[k], rf_index[k]);
            $display("dut%0d rf accept addr=%h", k, m_paddr[k]);
        end
        m_done[k] = done_next;
    endtask

    // Per-cycle model comparison on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("d%0d_rst_mem_valid", k), mem_valid[k], 0);
                chk($sformatf("d%0d_rst_rf_done", k), rf_done[k], 0);
                chk($sformatf("d%0d_rst_wb_ready", k), wb_ready[k], 1);
                chk($sformatf("d%0d_rst_rf_ready", k), rf_ready[k], 1);
                model_reset(k);
            end else begin
                model_cycle(k);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: actual=no finish required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wb_valid[k] = 0; wb_tag[k] = 0; wb_index[k] = 0; wb_data[k] = 0;
            rf_valid[k] = 0; rf_tag[k] = 0; rf_index[k] = 0;
            mem_ready[k] = 0; mem_rvalid[k] = 0; mem_rdata[k] = 0;
            model_reset(k);
        end
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk("reset_wb_ready", wb_ready[k], 1);
            chk("reset_rf_ready", rf_ready[k], 1);
            chk("reset_mem_valid", mem_valid[k], 0);
            chk("reset_rf_done", rf_done[k], 0);
            chk("reset_rf_data", rf_data[k], 0);
        end
        cyc();
        rst_n = 1'b1;

        // single writeback, INDEX_W=5
        mem_ready[0] = 1;
        wb_valid[0] = 1; wb_tag[0] = 32'h0ABCDE; wb_index[0] = 5'd3; wb_data[0] = 32'hDEADBEEF;
        cyc();
        wb_valid[0] = 0;
        chk("t1_mem_valid", mem_valid[0], 1);
        chk("t1_mem_we", mem_we[0], 1);
        chk("t1_mem_addr", mem_addr[0], 32'h055E6F0C);
        chk("t1_mem_wdata", mem_wdata[0], 32'hDEADBEEF);
        cyc();
        chk("t1_back_idle", mem_valid[0], 0);

        // refill accepted with one writeback queued
        wb_valid[0] = 1; wb_tag[0] = 32'h1; wb_index[0] = 5'd1; wb_data[0] = 32'hA1;
        cyc();
        wb_tag[0] = 32'h1FFFFFF; wb_index[0] = 5'h1F; wb_data[0] = 32'hA2;
        chk("t2_w1_addr", mem_addr[0], 32'h00000084);
        chk("t2_w1_data", mem_wdata[0], 32'hA1);
        cyc();
        wb_valid[0] = 0;
        rf_valid[0] = 1; rf_tag[0] = 32'h0123456; rf_index[0] = 5'h10;
        chk("t2_rf_ready_fifo1", rf_ready[0], 1);
        chk("t2_idle_between", mem_valid[0], 0);
        cyc();
        rf_valid[0] = 0;
        chk("t2_w2_first_valid", mem_valid[0], 1);
        chk("t2_w2_first_we", mem_we[0], 1);
        chk("t2_w2_addr", mem_addr[0], 32'hFFFFFFFC);
        chk("t2_w2_data", mem_wdata[0], 32'hA2);
        cyc();
        chk("t2_idle_after_w2", mem_valid[0], 0);
        cyc();
        chk("t2_rd_valid", mem_valid[0], 1);
        chk("t2_rd_we", mem_we[0], 0);
        chk("t2_rd_addr", mem_addr[0], 32'h091A2B40);
        cyc();
        chk("t2_wait_valid", mem_valid[0], 0);
        mem_rvalid[0] = 1; mem_rdata[0] = 32'h12345678;
        cyc();
        mem_rvalid[0] = 0;
        chk("t2_rf_done", rf_done[0], 1);
        chk("t2_rf_data", rf_data[0], 32'h12345678);
        cyc();
        chk("t2_rf_done_one_cycle", rf_done[0], 0);

        // writeback pushed during RF_WAIT, then stray rvalid in IDLE
        rf_valid[0] = 1; rf_tag[0] = 32'h2; rf_index[0] = 5'd2;
        cyc();
        rf_valid[0] = 0;
        chk("t3_rd_addr", mem_addr[0], 32'h00000108);
        chk("t3_rd_we", mem_we[0], 0);
        cyc();
        wb_valid[0] = 1; wb_tag[0] = 32'h3; wb_index[0] = 5'd4; wb_data[0] = 32'hA3;
        chk("t3_wb_ready_in_wait", wb_ready[0], 1);
        cyc();
        wb_valid[0] = 0;
        chk("t3_wb_held_in_wait", mem_valid[0], 0);
        mem_rvalid[0] = 1; mem_rdata[0] = 32'hCAFEF00D;
        cyc();
        mem_rvalid[0] = 0;
        chk("t3_rf_done", rf_done[0], 1);
        chk("t3_rf_data", rf_data[0], 32'hCAFEF00D);
        chk("t3_no_wr_yet", mem_valid[0], 0);
        cyc();
        chk("t3_wr_valid", mem_valid[0], 1);
        chk("t3_wr_addr", mem_addr[0], 32'h00000190);
        chk("t3_wr_data", mem_wdata[0], 32'hA3);
        cyc();
        mem_rvalid[0] = 1; mem_rdata[0] = 32'hBAD0BAD0;
        cyc();
        mem_rvalid[0] = 0;
        chk("t3_stray_no_done", rf_done[0], 0);
        cyc();
        chk("t3_stray_no_done2", rf_done[0], 0);

        // INDEX_W=2: FIFO fills, third push refused
        mem_ready[1] = 0;
        wb_valid[1] = 1; wb_tag[1] = 32'h1; wb_index[1] = 5'd0; wb_data[1] = 32'hB1;
        cyc();
        wb_tag[1] = 32'hABCDEF0; wb_index[1] = 5'd3; wb_data[1] = 32'hB2;
        chk("t4_ready_2nd", wb_ready[1], 1);
        chk("t4_a_addr", mem_addr[1], 32'h00000010);
        cyc();
        wb_tag[1] = 32'h7; wb_index[1] = 5'd1; wb_data[1] = 32'hB3;
        chk("t4_full", wb_ready[1], 0);
        cyc();
        chk("t4_still_full", wb_ready[1], 0);
        chk("t4_a_stable", mem_addr[1], 32'h00000010);
        chk("t4_a_data_stable", mem_wdata[1], 32'hB1);
        wb_valid[1] = 0;
        mem_ready[1] = 1;
        cyc();
        chk("t4_ready_after_pop", wb_ready[1], 1);
        chk("t4_idle_between", mem_valid[1], 0);
        cyc();
        chk("t4_b_valid", mem_valid[1], 1);
        chk("t4_b_addr", mem_addr[1], 32'hABCDEF0C);
        chk("t4_b_data", mem_wdata[1], 32'hB2);
        cyc();
        chk("t4_done_idle", mem_valid[1], 0);
        mem_ready[1] = 0;

        // reset during RF_REQ with memory stalled
        rf_valid[1] = 1; rf_tag[1] = 32'h5; rf_index[1] = 5'd1;
        cyc();
        rf_valid[1] = 0;
        chk("t5_rd_valid", mem_valid[1], 1);
        chk("t5_rd_addr", mem_addr[1], 32'h00000054);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_mem_valid", mem_valid[1], 0);
        chk("t5_rst_mem_addr", mem_addr[1], 0);
        cyc();
        rst_n = 1'b1;
        chk("t5_rf_ready", rf_ready[1], 1);
        chk("t5_wb_ready", wb_ready[1], 1);
        chk("t5_mem_valid", mem_valid[1], 0);
        mem_rvalid[1] = 1; mem_rdata[1] = 32'h55555555;
        cyc();
        mem_rvalid[1] = 0;
        chk("t5_no_done", rf_done[1], 0);
        cyc();
        chk("t5_no_done2", rf_done[1], 0);
        chk("t5_no_request", mem_valid[1], 0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
